switch_debounce2: RTL and testbench

- Two-channel input conditioner for the board slide switches.
- Synchronises, debounces and edge-detects two raw switch inputs.
- Drives the clean `a` and `b` levels consumed directly by the two-input logic-gate stage (whose six outputs go to the LEDs).
- Also provides single-cycle rise/fall pulses per channel for downstream counters and indicators.

---
 rtl/switch_debounce2_if.sv | 22 ++
 rtl/switch_debounce2.sv | 101 ++++++++++
 tb/tb_switch_debounce2.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/switch_debounce2_if.sv
// Switch conditioner signal bundle: raw switches in, clean levels
// and edge pulses out.
interface switch_debounce2_if;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  modport master (
    output sw_a, sw_b,
    input  a, b, a_rise, a_fall, b_rise, b_fall
  );

  modport slave (
    input  sw_a, sw_b,
    output a, b, a_rise, a_fall, b_rise, b_fall
  );
endinterface

// File: rtl/switch_debounce2.sv
// Two-channel slide-switch conditioner: synchronise, debounce and
// edge-detect sw_a/sw_b into clean a/b levels plus rise/fall pulses.
module switch_debounce2_chan #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 20,
  parameter int STABLE_COUNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sr;
  logic                   sync;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   out_d;

  assign sync = sr[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt;
    out_d = out;
    unique case (1'b1)
      (sync == out): cnt_d = '0;
      (sync != out && cnt == LAST): begin
        out_d = sync;
        cnt_d = '0;
      end
      (sync != out && cnt != LAST): cnt_d = cnt + 1'b1;
    endcase
  end

  // pulses are taken from the same edge that commits the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], raw};
      cnt  <= cnt_d;
      out  <= out_d;
      rise <= out_d & ~out;
      fall <= ~out_d & out;
    end
  end
endmodule

module switch_debounce2 #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 20,
  parameter int STABLE_COUNT = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_debounce2_if.slave  sif
);
  logic a_out, a_r, a_f;
  logic b_out, b_r, b_f;

  switch_debounce2_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_WIDTH   (CNT_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sif.sw_a),
    .out  (a_out),
    .rise (a_r),
    .fall (a_f)
  );

  switch_debounce2_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_WIDTH   (CNT_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sif.sw_b),
    .out  (b_out),
    .rise (b_r),
    .fall (b_f)
  );

  assign sif.a      = a_out;
  assign sif.b      = b_out;
  assign sif.a_rise = a_r;
  assign sif.a_fall = a_f;
  assign sif.b_rise = b_r;
  assign sif.b_fall = b_f;
endmodule

// File: tb/tb_switch_debounce2.sv
// Scoreboard bench for switch_debounce2: stimulus pushes expected
// pulse events, a negedge monitor pops and compares them.
module tb_switch_debounce2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_n = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int         en;
    logic [5:0] v;
  } ev_t;

  ev_t q[$];

  switch_debounce2_if sif();

  switch_debounce2 #(
    .SYNC_STAGES (2),
    .CNT_WIDTH   (3),
    .STABLE_COUNT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(string nm, int act, int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {sif.a, sif.b, sif.a_rise, sif.a_fall,
            sif.b_rise, sif.b_fall};
  endfunction

  // expected vector {a,b,a_rise,a_fall,b_rise,b_fall} after edge en
  task automatic push(int en, logic [5:0] v);
    ev_t e;
    e.en = en;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic w(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [5:0] o;
    ev_t e;
    o = outs();
    if (rst_n && (o[3:0] != 4'b0)) begin
      if (q.size() == 0) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL unexpected_pulse: got %b at edge %0d",
                 o, edge_n);
      end else begin
        e = q.pop_front();
        chk("pulse_edge", edge_n, e.en);
        chk("pulse_vec", int'(o), int'(e.v));
      end
    end
  end

  initial begin
    int e0;
    sif.sw_a = 1'b0;
    sif.sw_b = 1'b0;
    #3;
    chk("rst_outs", int'(outs()), 0);
    chk("rst_cnt_a", int'(dut.u_a.cnt), 0);
    w(2);
    rst_n = 1'b1;
    w(3);

    // 1: clean rise on A
    e0 = edge_n;
    sif.sw_a = 1'b1;
    push(e0 + 6, 6'b10_10_00);
    w(5);
    chk("t1_a_before", int'(sif.a), 0);
    w(2);
    chk("t1_a_after", int'(sif.a), 1);
    chk("t1_b", int'(sif.b), 0);
    w(3);

    // 6: clean fall on A
    e0 = edge_n;
    sif.sw_a = 1'b0;
    push(e0 + 6, 6'b00_01_00);
    w(5);
    chk("t6_a_before", int'(sif.a), 1);
    w(2);
    chk("t6_a_after", int'(sif.a), 0);
    w(3);

    // 2: bounce 1,0,1,0 then hold 1
    sif.sw_a = 1'b1; w(1);
    sif.sw_a = 1'b0; w(1);
    sif.sw_a = 1'b1; w(1);
    sif.sw_a = 1'b0; w(1);
    e0 = edge_n;
    sif.sw_a = 1'b1;
    push(e0 + 6, 6'b10_10_00);
    w(5);
    chk("t2_a_before", int'(sif.a), 0);
    w(2);
    chk("t2_a_after", int'(sif.a), 1);
    e0 = edge_n;
    sif.sw_a = 1'b0;
    push(e0 + 6, 6'b00_01_00);
    w(9);

    // 3: 3-cycle glitch on B is one short of the count
    sif.sw_b = 1'b1;
    w(3);
    sif.sw_b = 1'b0;
    w(8);
    chk("t3_b", int'(sif.b), 0);
    chk("t3_cnt_b", int'(dut.u_b.cnt), 0);

    // 4: simultaneous rise then fall
    e0 = edge_n;
    sif.sw_a = 1'b1;
    sif.sw_b = 1'b1;
    push(e0 + 6, 6'b11_10_10);
    w(9);
    chk("t4_ab_high", int'({sif.a, sif.b}), 3);
    e0 = edge_n;
    sif.sw_a = 1'b0;
    sif.sw_b = 1'b0;
    push(e0 + 6, 6'b00_01_01);
    w(9);
    chk("t4_ab_low", int'({sif.a, sif.b}), 0);

    // 5: reset between edges 4 and 5 of a pending rise
    e0 = edge_n;
    sif.sw_a = 1'b1;
    w(4);
    chk("t5_cnt_pre", int'(dut.u_a.cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cnt_rst", int'(dut.u_a.cnt), 0);
    chk("t5_sync_rst", int'(dut.u_a.sr), 0);
    chk("t5_outs_rst", int'(outs()), 0);
    w(2);
    e0 = edge_n;
    rst_n = 1'b1;
    push(e0 + 6, 6'b10_10_00);
    w(5);
    chk("t5_a_before", int'(sif.a), 0);
    w(2);
    chk("t5_a_after", int'(sif.a), 1);
    w(6);

    chk("missing_pulses", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
